// File: rtl/approx_seq_mult_ctrl_pkg.sv
// Shared types and elaboration checks for the approximate
// shift-and-add multiplier controller.
package approx_seq_mult_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam int MIN_WIDTH = 2;
  localparam int MAX_WIDTH = 32;

  function automatic int prod_w(input int w);
    return 2 * w;
  endfunction

  function automatic bit width_ok(input int w);
    return (w >= MIN_WIDTH) && (w <= MAX_WIDTH);
  endfunction

  function automatic bit approx_ok(input int w, input int ab);
    return (ab >= 0) && (ab <= w);
  endfunction

endpackage

// File: rtl/approx_adder_row.sv
// WIDTH-column ripple row; the low APPROX_BITS columns
// use approximate carry.
module approx_adder_row #(
  parameter int WIDTH       = 8,
  parameter int APPROX_BITS = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  logic [WIDTH:0] c;

  assign c[0] = 1'b0;
  assign cout = c[WIDTH];

  for (genvar i = 0; i < WIDTH; i++) begin : g_col
    param_full_adder #(
      .APPROX(i < APPROX_BITS)
    ) u_fa (
      .a   (a[i]),
      .b   (b[i]),
      .cin (c[i]),
      .sum (sum[i]),
      .cout(c[i+1])
    );
  end

endmodule

// File: rtl/param_full_adder.sv
// One adder column; APPROX=1 replaces the carry with a|b.
module param_full_adder #(
  parameter bit APPROX = 1'b0
) (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum = a ^ b ^ cin;

  if (APPROX) begin : g_apx
    assign cout = a | b;
  end else begin : g_exact
    assign cout = (a & b) | (cin & (a ^ b));
  end

endmodule

// File: rtl/approx_seq_mult_ctrl.sv
// Sequential approximate multiplier controller.
// Optional: SEQ_MULT_EARLY_EXIT_EN skips trailing zero steps.
module approx_seq_mult_ctrl
  import approx_seq_mult_ctrl_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int APPROX_BITS = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   out_p,
  output logic                 busy,
  output logic                 add_en
);

  localparam int PW = prod_w(WIDTH);
  localparam int KW = $clog2(WIDTH);

  if (!width_ok(WIDTH)) begin : g_bad_width
    $error("WIDTH out of range 2..32");
  end
  if (!approx_ok(WIDTH, APPROX_BITS)) begin : g_bad_apx
    $error("APPROX_BITS out of range 0..WIDTH");
  end

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [PW:0]       p_q, p_d;
  logic [KW-1:0]     k_q, k_d;
  logic              out_valid_q, out_valid_d;
  logic              busy_q, busy_d;
  logic              in_ready_q, in_ready_d;

  logic [WIDTH-1:0]  u_cur;
  logic [WIDTH-1:0]  l_cur;
  logic [WIDTH-1:0]  row_sum;
  logic              row_cout;
  logic              last;

  assign u_cur = p_q[PW-1:WIDTH];
  assign l_cur = p_q[WIDTH-1:0];
  assign last  = (k_q == KW'(WIDTH - 1));

  approx_adder_row #(
    .WIDTH      (WIDTH),
    .APPROX_BITS(APPROX_BITS)
  ) u_row (
    .a   (u_cur),
    .b   (a_q),
    .sum (row_sum),
    .cout(row_cout)
  );

`ifdef SEQ_MULT_EARLY_EXIT_EN
  logic [WIDTH-1:0] live_mask;
  logic             early;
  logic [PW:0]      p_exit;

  // bits of L still waiting to be consumed at step k
  always_comb begin
    live_mask = {WIDTH{1'b1}} >> k_q;
    early     = ((l_cur & live_mask) == '0);
    p_exit    = p_q >> (WIDTH - int'(k_q));
  end
`endif

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    p_d         = p_q;
    k_d         = k_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;
    in_ready_d  = in_ready_q;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready_q) begin
          a_d        = in_a;
          p_d        = {1'b0, {WIDTH{1'b0}}, in_b};
          k_d        = '0;
          state_d    = S_RUN;
          busy_d     = 1'b1;
          in_ready_d = 1'b0;
        end
      end
      S_RUN: begin
        if (l_cur[0]) begin
          p_d = {1'b0, row_cout, row_sum,
                 l_cur[WIDTH-1:1]};
        end else begin
          p_d = {1'b0, p_q[PW:1]};
        end
        k_d = k_q + 1'b1;
        if (last) begin
          state_d     = S_DONE;
          out_valid_d = 1'b1;
          k_d         = '0;
        end
`ifdef SEQ_MULT_EARLY_EXIT_EN
        if (early) begin
          p_d         = p_exit;
          state_d     = S_DONE;
          out_valid_d = 1'b1;
          k_d         = '0;
        end
`endif
      end
      S_DONE: begin
        if (out_ready) begin
          state_d     = S_IDLE;
          out_valid_d = 1'b0;
          busy_d      = 1'b0;
          in_ready_d  = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      a_q         <= '0;
      p_q         <= '0;
      k_q         <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      p_q         <= p_d;
      k_q         <= k_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q & ~rst;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign out_p     = out_valid_q ? p_q[PW-1:0] : '0;
  assign add_en    = (state_q == S_RUN) & l_cur[0] & ~rst;

endmodule

// File: tb/tb_approx_seq_mult_ctrl.sv
// Bench: three lockstep instances (APPROX_BITS 0/4/8)
// against a window-add reference model.
module tb_approx_seq_mult_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         out_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;

  logic           rdy [3];
  logic           ov  [3];
  logic [2*W-1:0] p   [3];
  logic           bsy [3];
  logic           ae  [3];

  logic [2*W-1:0] last_p [3];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    approx_seq_mult_ctrl #(
      .WIDTH      (W),
      .APPROX_BITS(g * 4)
    ) u_dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_ready (rdy[g]),
      .in_a     (in_a),
      .in_b     (in_b),
      .out_valid(ov[g]),
      .out_ready(out_ready),
      .out_p    (p[g]),
      .busy     (bsy[g]),
      .add_en   (ae[g])
    );
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Adds a into the W-bit window of acc starting at
  // bit pos; window column i approximates iff i < ab.
  function automatic logic [2*W:0] add_win(
      input logic [2*W:0] acc, input logic [W-1:0] a,
      input int pos, input int ab);
    logic [2*W:0] r;
    logic c, x, y;
    r = acc;
    c = 1'b0;
    for (int i = 0; i < W; i++) begin
      x = acc[pos+i];
      y = a[i];
      r[pos+i] = x ^ y ^ c;
      if (i < ab) c = x | y;
      else        c = (x & y) | (c & (x ^ y));
    end
    r[pos+W] = c;
    return r;
  endfunction

  function automatic logic [2*W-1:0] prod_m(
      input logic [W-1:0] a, input logic [W-1:0] b,
      input int ab);
    logic [2*W:0] acc = '0;
    for (int i = 0; i < W; i++)
      if (b[i]) acc = add_win(acc, a, i, ab);
    return acc[2*W-1:0];
  endfunction

  function automatic int lat_m(input logic [W-1:0] b);
`ifdef SEQ_MULT_EARLY_EXIT_EN
    int n = 0;
    while (n < W && (b >> n) != 0) n++;
    return (n < W) ? n + 1 : W;
`else
    return W;
`endif
  endfunction

  task automatic do_op(input logic [W-1:0] a,
                       input logic [W-1:0] b,
                       input int hold,
                       input bit rdy_early);
    int g = 0;
    int lat = 0;
    int adds = 0;
    int rbad = 0;
    logic [2*W-1:0] p0;
    in_a = a;
    in_b = b;
    in_valid = 1'b1;
    out_ready = 1'b0;
    while (!rdy[0] && g < 50) begin
      @(posedge clk); #1; g++;
    end
    chk("in_rdy", 32'(rdy[0]), 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    out_ready = rdy_early;
    while (!ov[0] && lat < 3 * W) begin
      if (ae[0]) adds++;
      if (rdy[0] || !bsy[0]) rbad++;
      @(posedge clk); #1; lat++;
    end
    chk("latency", lat, lat_m(b));
    chk("add_en_cnt", adds, $countones(b));
    chk("rdy_busy", rbad, 0);
    chk("p_exact", 32'(p[0]), 32'(16'(a) * 16'(b)));
    chk("p_apx4", 32'(p[1]), 32'(prod_m(a, b, 4)));
    chk("p_apx8", 32'(p[2]), 32'(prod_m(a, b, 8)));
    for (int i = 0; i < 3; i++) last_p[i] = p[i];
    p0 = p[0];
    repeat (hold) begin
      @(posedge clk); #1;
      chk("hold_p", 32'(p[0]), 32'(p0));
      chk("hold_rdy", 32'(rdy[0]), 0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("ov_drop", 32'(ov[0]), 0);
    chk("rdy_back", 32'(rdy[0]), 1);
  endtask

  task automatic b2b();
    int e = 0;
    int na = 0;
    int nh = 0;
    int bad = 0;
    int acc_e [2] = '{0, 0};
    int hs_e  [2] = '{0, 0};
    logic [2*W-1:0] hp [2] = '{0, 0};
    logic fi, fo;
    logic [2*W-1:0] pcap;
    in_a = 2;
    in_b = 5;
    in_valid = 1'b1;
    out_ready = 1'b1;
    while (nh < 2 && e < 100) begin
      fi = in_valid && rdy[0];
      fo = ov[0] && out_ready;
      pcap = p[0];
      if (bsy[0] && rdy[0]) bad++;
      @(posedge clk); #1; e++;
      if (fi) begin
        if (na < 2) acc_e[na] = e;
        na++;
        if (na == 1) begin
          in_a = 9;
          in_b = 9;
        end else begin
          in_valid = 1'b0;
        end
      end
      if (fo) begin
        if (nh < 2) begin
          hs_e[nh] = e;
          hp[nh] = pcap;
        end
        nh++;
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    chk("b2b_count", nh, 2);
    chk("b2b_p1", 32'(hp[0]), 10);
    chk("b2b_p2", 32'(hp[1]), 81);
    chk("b2b_gap", acc_e[1], hs_e[0] + 1);
    chk("b2b_rdy", bad, 0);
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    int hold;
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    in_a = '0;
    in_b = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rdy", 32'(rdy[0]), 0);
    chk("rst_ov", 32'(ov[0]), 0);
    chk("rst_p", 32'(p[0]), 0);
    chk("rst_busy", 32'(bsy[0]), 0);
    chk("rst_add_en", 32'(ae[0]), 0);
    rst = 1'b0;
    #1;
    chk("rst_rdy_rel", 32'(rdy[0]), 1);

    do_op(13, 11, 0, 1'b0);
    chk("d_13x11", 32'(last_p[0]), 143);
    do_op(255, 255, 5, 1'b0);
    chk("d_255x255", 32'(last_p[0]), 65025);
    do_op(3, 3, 1, 1'b0);
    chk("d_3x3_ex", 32'(last_p[0]), 9);
    chk("d_3x3_apx", 32'(last_p[2]), 15);
    do_op(77, 0, 0, 1'b0);
    chk("d_77x0", 32'(last_p[0]), 0);

    // abort mid-run at step k=4
    in_a = 200;
    in_b = 255;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("ab_ov", 32'(ov[0]), 0);
    chk("ab_p", 32'(p[0]), 0);
    chk("ab_busy", 32'(bsy[0]), 0);
    chk("ab_add_en", 32'(ae[0]), 0);
    chk("ab_rdy", 32'(rdy[0]), 0);
    rst = 1'b0;
    #1;
    chk("ab_rdy_rel", 32'(rdy[0]), 1);
    do_op(6, 7, 0, 1'b0);
    chk("d_6x7", 32'(last_p[0]), 42);

    b2b();

    for (int n = 0; n < 40; n++) begin
      ra = W'($urandom_range(0, 255));
      rb = W'($urandom_range(0, 255) >> $urandom_range(0, 7));
      hold = $urandom_range(0, 3);
      do_op(ra, rb, hold, (hold == 0) && ($urandom_range(0, 1) == 1));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
